// File: rtl/shift_unit_arbiter_if.sv
// rtl/shift_unit_arbiter_if.sv - request/response bundle for the shared shifter
// Two requester ports plus the single result port; the arbiter takes the slave side.
interface shift_unit_arbiter_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               req0_valid;
  logic               req0_ready;
  logic [WIDTH-1:0]   req0_data;
  logic [SHAMT_W-1:0] req0_shamt;
  logic               req0_op;
  logic               req1_valid;
  logic               req1_ready;
  logic [WIDTH-1:0]   req1_data;
  logic [SHAMT_W-1:0] req1_shamt;
  logic               req1_op;
  logic               resp_valid;
  logic               resp_ready;
  logic [WIDTH-1:0]   resp_data;
  logic               resp_id;

  modport master (
    output req0_valid, req0_data, req0_shamt, req0_op,
    output req1_valid, req1_data, req1_shamt, req1_op,
    output resp_ready,
    input  req0_ready, req1_ready, resp_valid, resp_data, resp_id
  );

  modport slave (
    input  req0_valid, req0_data, req0_shamt, req0_op,
    input  req1_valid, req1_data, req1_shamt, req1_op,
    input  resp_ready,
    output req0_ready, req1_ready, resp_valid, resp_data, resp_id
  );
endinterface

// File: rtl/shift_unit_arbiter.sv
// rtl/shift_unit_arbiter.sv - round-robin arbiter sharing one barrel shifter
// Two ALU lanes share a single SLL/SRA datapath; one registered result stage.
module shift_unit_arbiter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic                clock,
  input  logic                reset,
  shift_unit_arbiter_if.slave bus
);
  logic               resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0]   resp_data_q, resp_data_d;
  logic               resp_id_q, resp_id_d;
  logic               last_grant_q, last_grant_d;
  logic [7:0]         gnt_cnt0_q, gnt_cnt0_d;
  logic [7:0]         gnt_cnt1_q, gnt_cnt1_d;
  logic               can_accept, grant0, grant1, acc0, acc1;
  logic [WIDTH-1:0]   sel_data;
  logic [SHAMT_W-1:0] sel_shamt;
  logic               sel_op;

  // Log2-staged shifter: stage i moves the operand by 2**i when shamt bit i is set.
  function automatic logic [WIDTH-1:0] barrel(input logic [WIDTH-1:0] d,
                                              input logic [SHAMT_W-1:0] s,
                                              input logic op);
    logic [WIDTH-1:0] x;
    x = d;
    for (int i = 0; i < SHAMT_W; i++) begin
      if (s[i]) begin
        if (op) x = $signed(x) >>> (1 << i);
        else    x = x << (1 << i);
      end
    end
    return x;
  endfunction

  assign can_accept = !resp_valid_q || bus.resp_ready;
  assign grant0     = bus.req0_valid && (!bus.req1_valid || last_grant_q);
  assign grant1     = bus.req1_valid && (!bus.req0_valid || !last_grant_q);

  assign bus.req0_ready = !reset && can_accept && grant0;
  assign bus.req1_ready = !reset && can_accept && grant1;
  assign acc0           = bus.req0_valid && bus.req0_ready;
  assign acc1           = bus.req1_valid && bus.req1_ready;

  assign sel_data  = acc1 ? bus.req1_data  : bus.req0_data;
  assign sel_shamt = acc1 ? bus.req1_shamt : bus.req0_shamt;
  assign sel_op    = acc1 ? bus.req1_op    : bus.req0_op;

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = resp_id_q;

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    last_grant_d = last_grant_q;
    gnt_cnt0_d   = gnt_cnt0_q;
    gnt_cnt1_d   = gnt_cnt1_q;
    if (acc0 || acc1) begin
      resp_valid_d = 1'b1;
      resp_data_d  = barrel(sel_data, sel_shamt, sel_op);
      resp_id_d    = acc1;
      last_grant_d = acc1;
      if (acc0 && gnt_cnt0_q != 8'hFF) gnt_cnt0_d = gnt_cnt0_q + 8'd1;
      if (acc1 && gnt_cnt1_q != 8'hFF) gnt_cnt1_d = gnt_cnt1_q + 8'd1;
    end else if (bus.resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
      last_grant_q <= 1'b1;
      gnt_cnt0_q   <= 8'd0;
      gnt_cnt1_q   <= 8'd0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      last_grant_q <= last_grant_d;
      gnt_cnt0_q   <= gnt_cnt0_d;
      gnt_cnt1_q   <= gnt_cnt1_d;
    end
  end
endmodule
